// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: word-addressed instruction memory, program counter and prefetch FIFO
// feeding the core over valid/ready. Optional HALT-opcode stop is enabled by FETCH_HALT_EN.
module instr_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic [31:0]       rdata_reg;
    logic [ADDR_W-1:0] raddr_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              inflight_reg;

    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic issue;
    logic push;
    logic pop;
    logic halt_push;
    logic halted_reg;

    assign pop  = instr_valid && instr_ready;
    // A redirect cancels the read that is returning this cycle.
    assign push = inflight_reg && !redirect;

`ifdef FETCH_HALT_EN
    assign halt_push = push && (rdata_reg[31:26] == 6'b111111);

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            halted_reg <= 1'b0;
        end else if (halt_push) begin
            halted_reg <= 1'b1;
        end
    end
`else
    assign halt_push  = 1'b0;
    assign halted_reg = 1'b0;
`endif

    // Credit check counts the in-flight read so a push can never overflow the FIFO;
    // the HALT word being pushed also blocks the issue on the same edge.
    assign issue = ((count_reg + CNT_W'(inflight_reg)) < CNT_W'(DEPTH))
                   && !redirect && !halted_reg && !halt_push;

    // Read-first memory: the registered read sees the old word on a same-address write.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
        if (issue) begin
            rdata_reg <= mem[pc_reg];
            raddr_reg <= pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_reg] <= rdata_reg;
            fifo_addr[wr_ptr_reg] <= raddr_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= '0;
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else if (redirect) begin
            pc_reg       <= redirect_pc;
            inflight_reg <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (issue) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
            inflight_reg <= issue;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign instr_valid = (count_reg != '0);
    assign instruction = instr_valid ? fifo_data[rd_ptr_reg] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_addr[rd_ptr_reg] : '0;
    assign halted      = halted_reg;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, back-pressure, redirect, wrap and HALT
// handling (HALT expectations follow FETCH_HALT_EN).
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [7:0]  instr_pc;
    logic        halted;

    int checks = 0;
    int failures = 0;

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_ready(instr_ready), .instr_valid(instr_valid),
        .instruction(instruction), .instr_pc(instr_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_head(input string tag, input logic [31:0] word, input logic [7:0] pc);
        check({tag, "_v"}, {31'h0, instr_valid}, 32'h1);
        check({tag, "_w"}, instruction, word);
        check({tag, "_pc"}, {24'h0, instr_pc}, {24'h0, pc});
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_v"}, {31'h0, instr_valid}, 32'h0);
        check({tag, "_w"}, instruction, 32'h0);
        check({tag, "_pc"}, {24'h0, instr_pc}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check_empty("rst");
        check("rst_halt", {31'h0, halted}, 32'h0);
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [7:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        // Program load during reset: word i holds 1+i.
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem_we = 1'b1;
            imem_waddr = 8'(i);
            imem_wdata = 32'h1 + 32'(i);
            tick();
        end
        imem_we = 1'b0;

        // 1. Streaming with ready held high: 2-cycle latency, then 1 word/cycle.
        instr_ready = 1'b1;
        do_reset();
        tick();
        check("lat_e0_v", {31'h0, instr_valid}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_head("stream", 32'h1 + 32'(k), 8'(k));
        end

        // 2. Back-pressure: FIFO fills, head stays word 0, then drains 1..8 in order.
        instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        check_head("full", 32'h1, 8'h0);
        instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_head("drain", 32'h1 + 32'(k), 8'(k));
            tick();
        end

        // 3. Redirect to 5 with three entries queued and one read in flight.
        instr_ready = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick();
        check_head("q3", 32'h1, 8'h0);
        do_redirect(8'd5);
        check_empty("redir_r");
        tick();
        check_empty("redir_r1");
        tick();
        check_head("redir_r2", 32'h6, 8'd5);
        instr_ready = 1'b1;
        tick();
        check_head("redir_nx", 32'h7, 8'd6);

        // 4. Address wrap from 254 to 1.
        do_redirect(8'd254);
        check_empty("wrap_r");
        tick();
        check_empty("wrap_r1");
        tick();
        check_head("wrap0", 32'd255, 8'd254);
        tick();
        check_head("wrap1", 32'd256, 8'd255);
        tick();
        check_head("wrap2", 32'd1, 8'd0);
        tick();
        check_head("wrap3", 32'd2, 8'd1);

        // 5. Redirect and pop of word pc=1 on the same edge; next word comes from 20.
        do_redirect(8'd20);
        check_empty("rp_r");
        tick();
        check_empty("rp_r1");
        tick();
        check_head("rp_first", 32'd21, 8'd20);
        tick();
        check_head("rp_next", 32'd22, 8'd21);

        // 6. HALT opcode at address 3.
        reset = 1'b1;
        imem_we = 1'b1;
        imem_waddr = 8'd3;
        imem_wdata = 32'hFC00_0000;
        tick();
        imem_we = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_head("h_pre", 32'h1 + 32'(k), 8'(k));
        end
        tick();
        check_head("h_word", 32'hFC00_0000, 8'd3);
`ifdef FETCH_HALT_EN
        check("h_halted", {31'h0, halted}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("h_stop_v", {31'h0, instr_valid}, 32'h0);
        end
        check("h_still", {31'h0, halted}, 32'h1);
        do_redirect(8'd0);
        check("h_clear", {31'h0, halted}, 32'h0);
        tick();
        tick();
        check_head("h_restart", 32'h1, 8'd0);
`else
        check("h_nohalt", {31'h0, halted}, 32'h0);
        tick();
        check_head("h_after", 32'h5, 8'd4);
        check("h_nohalt2", {31'h0, halted}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
